// File: rtl/pid_out_slew.sv
// Per-channel output conditioner for the PID-to-DAC stream: clamps to programmable limits,
// applies a slew-rate limit and ramps between the park value and live tracking.
module pid_out_slew #(
    parameter int unsigned DW = 14,
    parameter int unsigned CW = 16
) (
    input  logic                 clk,
    input  logic                 rstn,

    input  logic signed [DW-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,

    output logic signed [DW-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,

    input  logic                 cfg_en,
    input  logic signed [DW-1:0] cfg_park,
    input  logic signed [DW-1:0] cfg_hi,
    input  logic signed [DW-1:0] cfg_lo,
    input  logic        [DW-2:0] cfg_step,
    input  logic                 cfg_clr,

    output logic        [1:0]    st_state,
    output logic                 st_clamp,
    output logic                 st_slew,
    output logic        [CW-1:0] st_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StPark = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic signed [DW-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  clamp_q, clamp_d;
    logic                  slew_q, slew_d;
    logic        [CW-1:0]  cnt_q, cnt_d;

    logic                  accept;
    logic                  idle_mode;
    logic signed [DW-1:0]  clamped;
    logic signed [DW-1:0]  tgt;
    logic signed [DW:0]    tgt_x;
    logic signed [DW:0]    data_x;
    logic signed [DW:0]    step_x;
    logic signed [DW:0]    diff;
    logic signed [DW-1:0]  step_w;
    logic signed [DW-1:0]  slewed;
    logic                  clamp_ev;
    logic                  slew_ev;

    assign s_ready = m_ready | ~valid_q;
    assign accept  = s_valid & s_ready;

    // IDLE with tracking disabled snaps straight to park, bypassing the slew limiter.
    assign idle_mode = ~cfg_en & (state_q == StIdle);

    always_comb begin
        clamped = s_data;
        if (s_data > cfg_hi) begin
            clamped = cfg_hi;
        end else if (s_data < cfg_lo) begin
            clamped = cfg_lo;
        end
    end

    assign tgt = cfg_en ? clamped : cfg_park;

    // Difference is formed one bit wider so full-scale swings cannot wrap.
    assign tgt_x  = tgt;
    assign data_x = data_q;
    assign step_x = {2'b00, cfg_step};
    assign diff   = tgt_x - data_x;
    assign step_w = {1'b0, cfg_step};

    always_comb begin
        slewed = tgt;
        if (cfg_step != '0) begin
            if (diff > step_x) begin
                slewed = data_q + step_w;
            end else if (diff < -step_x) begin
                slewed = data_q - step_w;
            end
        end
    end

    assign data_d   = idle_mode ? cfg_park : slewed;
    assign clamp_ev = accept & cfg_en & (clamped != s_data);
    assign slew_ev  = accept & ~idle_mode & (slewed != tgt);

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                StRun:   state_d = cfg_en ? StRun : StPark;
                StPark: begin
                    if (cfg_en) begin
                        state_d = StRun;
                    end else if (data_d == cfg_park) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = cfg_en ? StRun : StIdle;
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (accept) begin
            valid_d = 1'b1;
        end else if (m_ready) begin
            valid_d = 1'b0;
        end
    end

    // A clear in the same cycle as an event wins; the event is dropped.
    always_comb begin
        clamp_d = clamp_q;
        slew_d  = slew_q;
        cnt_d   = cnt_q;
        if (cfg_clr) begin
            clamp_d = 1'b0;
            slew_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            if (clamp_ev) begin
                clamp_d = 1'b1;
            end
            if (slew_ev) begin
                slew_d = 1'b1;
                if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            data_q  <= '0;
            valid_q <= 1'b0;
            clamp_q <= 1'b0;
            slew_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            clamp_q <= clamp_d;
            slew_q  <= slew_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                data_q <= data_d;
            end
        end
    end

    assign m_data   = data_q;
    assign m_valid  = valid_q;
    assign st_state = state_q;
    assign st_clamp = clamp_q;
    assign st_slew  = slew_q;
    assign st_cnt   = cnt_q;

endmodule
